// File: rtl/store_buffer_ext.sv
// store_buffer_ext: turns sw/sh/sb requests into word-aligned DM writes with
// byte enables and lane-replicated data, queued in a small in-order FIFO
// drained by a valid/ready handshake. Also flags misaligned stores and
// reports loads that hit a word with a store still pending.
module store_buffer_ext #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [1:0]    st_op,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  output logic          st_misalign,
  input  logic [31:0]   ld_addr,
  output logic          ld_hazard,
  output logic          m_valid,
  output logic [31:0]   m_addr,
  output logic [31:0]   m_wdata,
  output logic [3:0]    m_byteen,
  input  logic          m_ready,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [29:0]   entry_addr  [DEPTH];
  logic [31:0]   entry_data  [DEPTH];
  logic [3:0]    entry_be    [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic [3:0]    new_be;
  logic [31:0]   new_data;
  logic          new_misalign;
  logic          enq;
  logic          deq;
  logic [PW-1:0] hz_offset;

  // The low two bits of the load address select a byte within the word and
  // play no part in the word-granular hazard compare.
  logic          unused_ld_low_bits;
  assign unused_ld_low_bits = ^ld_addr[1:0];

  // Lane formation and alignment check for the incoming store request.
  always_comb begin
    new_be       = 4'b0000;
    new_data     = 32'h0;
    new_misalign = 1'b0;
    case (st_op)
      2'b00: begin
        new_be       = 4'b1111;
        new_data     = st_data;
        new_misalign = (st_addr[1:0] != 2'b00);
      end
      2'b01: begin
        new_be       = st_addr[1] ? 4'b1100 : 4'b0011;
        new_data     = {2{st_data[15:0]}};
        new_misalign = st_addr[0];
      end
      2'b10: begin
        new_be       = 4'b0001 << st_addr[1:0];
        new_data     = {4{st_data[7:0]}};
      end
      default: begin
        new_misalign = 1'b1;
      end
    endcase
  end

  assign st_misalign = st_valid & new_misalign;
  assign st_ready    = (count != CW'(DEPTH));
  assign empty       = (count == '0);
  assign m_valid     = ~empty;
  assign enq         = st_valid & st_ready & ~new_misalign;
  assign deq         = m_valid & m_ready;

  assign m_addr   = empty ? 32'h0 : {entry_addr[rd_ptr], 2'b00};
  assign m_wdata  = empty ? 32'h0 : entry_data[rd_ptr];
  assign m_byteen = empty ? 4'h0  : entry_be[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards any pending entries.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only observed while the slot is occupied.
  always_ff @(posedge clk) begin
    if (enq) begin
      entry_addr[wr_ptr] <= st_addr[31:2];
      entry_data[wr_ptr] <= new_data;
      entry_be[wr_ptr]   <= new_be;
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    ld_hazard = 1'b0;
    hz_offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hz_offset = PW'(i) - rd_ptr;
      if (({1'b0, hz_offset} < count) && (entry_addr[i] == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer_ext.sv
// tb_store_buffer_ext: directed and randomized stimulus for store_buffer_ext,
// checked every cycle against a queue-based reference of the store buffer.
module tb_store_buffer_ext;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        st_misalign;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_byteen;
  logic        m_ready;
  logic [1:0]  count;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;

  localparam int MDEPTH = 2;

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];
  logic [3:0]  q_be   [$];

  store_buffer_ext #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen),
    .m_ready(m_ready), .count(count), .empty(empty)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_misaligned(input logic [1:0] op, input logic [31:0] a);
    return (op == 2'd3) || (op == 2'd0 && (a % 4) != 0) || (op == 2'd1 && (a % 2) != 0);
  endfunction

  function automatic logic [31:0] ref_data(input logic [1:0] op, input logic [31:0] d);
    if (op == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    if (op == 2'd2) return (d & 32'hFF) * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] op, input logic [31:0] a);
    int sh;
    sh = a % 4;
    if (op == 2'd1) return 4'(3 << sh);
    if (op == 2'd2) return 4'(1 << sh);
    return 4'hF;
  endfunction

  // Compare every DUT output against the reference for the current inputs.
  task automatic checkOutput();
    int sz;
    logic hz;
    sz = q_addr.size();
    hz = 1'b0;
    foreach (q_addr[k]) if (q_addr[k][31:2] == ld_addr[31:2]) hz = 1'b1;
    chk("st_ready",    32'(st_ready),    32'(sz < MDEPTH));
    chk("st_misalign", 32'(st_misalign), 32'(st_valid && ref_misaligned(st_op, st_addr)));
    chk("ld_hazard",   32'(ld_hazard),   32'(hz));
    chk("m_valid",     32'(m_valid),     32'(sz != 0));
    chk("empty",       32'(empty),       32'(sz == 0));
    chk("count",       32'(count),       32'(sz));
    chk("m_addr",      m_addr,           (sz != 0) ? q_addr[0] : 32'h0);
    chk("m_wdata",     m_wdata,          (sz != 0) ? q_data[0] : 32'h0);
    chk("m_byteen",    32'(m_byteen),    (sz != 0) ? 32'(q_be[0]) : 32'h0);
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] la,
                               input logic mr, input logic rst_n);
    logic do_enq, do_deq;
    st_valid = v; st_op = op; st_addr = a; st_data = d;
    ld_addr = la; m_ready = mr; reset = rst_n;
    #1;
    checkOutput();
    do_enq = v && (q_addr.size() < MDEPTH) && !ref_misaligned(op, a);
    do_deq = (q_addr.size() != 0) && mr;
    @(posedge clk);
    if (!rst_n) begin
      q_addr.delete(); q_data.delete(); q_be.delete();
    end else begin
      if (do_deq) begin
        void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_be.pop_front());
      end
      if (do_enq) begin
        q_addr.push_back(a & 32'hFFFF_FFFC);
        q_data.push_back(ref_data(op, d));
        q_be.push_back(ref_be(op, a));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    st_valid = 0; st_op = 0; st_addr = 0; st_data = 0; ld_addr = 0; m_ready = 0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] reset state");
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 0, 1);

    $display("[TB] sb lane replication");
    applyStimulus(1, 2'd2, 32'h1003, 32'h0000_00A5, 32'h100, 1, 1);
    chk("t1_m_valid",  32'(m_valid),  32'd1);
    chk("t1_m_addr",   m_addr,        32'h1000);
    chk("t1_m_byteen", 32'(m_byteen), 32'h8);
    chk("t1_m_wdata",  m_wdata,       32'hA5A5_A5A5);
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 1, 1);
    chk("t1_empty", 32'(empty), 32'd1);

    $display("[TB] sh lanes and misalignment");
    applyStimulus(1, 2'd1, 32'h2002, 32'h1234_BEEF, 32'h100, 0, 1);
    chk("t2_m_byteen", 32'(m_byteen), 32'hC);
    chk("t2_m_wdata",  m_wdata,       32'hBEEF_BEEF);
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 1, 1);
    applyStimulus(1, 2'd1, 32'h2001, 32'h1234_BEEF, 32'h100, 0, 1);
    chk("t2_misalign", 32'(st_misalign), 32'd1);
    chk("t2_count",    32'(count),       32'd0);

    $display("[TB] fill and ordered drain");
    applyStimulus(1, 2'd0, 32'h5000, 32'h1111_1111, 32'h100, 0, 1);
    applyStimulus(1, 2'd0, 32'h5004, 32'h2222_2222, 32'h100, 0, 1);
    chk("t3_count_full", 32'(count),    32'd2);
    chk("t3_st_ready",   32'(st_ready), 32'd0);
    applyStimulus(1, 2'd0, 32'h5008, 32'h3333_3333, 32'h100, 0, 1);
    chk("t3_count_drop", 32'(count),  32'd2);
    chk("t3_head0",      m_addr,      32'h5000);
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 1, 1);
    chk("t3_count_1",    32'(count),  32'd1);
    chk("t3_head1",      m_wdata,     32'h2222_2222);
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 1, 1);
    chk("t3_count_0",    32'(count),  32'd0);

    $display("[TB] full with simultaneous dequeue, then wrap");
    applyStimulus(1, 2'd0, 32'h6000, 32'hA, 32'h100, 0, 1);
    applyStimulus(1, 2'd0, 32'h6004, 32'hB, 32'h100, 0, 1);
    applyStimulus(1, 2'd0, 32'h6008, 32'hC, 32'h100, 1, 1);
    chk("t4_count_full_deq", 32'(count), 32'd1);
    chk("t4_head",           m_addr,     32'h6004);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 2'd0, 32'h7000 + 32'(4 * i), 32'(i), 32'h100, 1, 1);
      chk("t4_wrap_count", 32'(count), 32'd1);
      chk("t4_wrap_head",  m_addr,     32'h7000 + 32'(4 * i));
    end
    applyStimulus(0, 2'd0, 0, 0, 32'h100, 1, 1);

    $display("[TB] load hazard");
    applyStimulus(1, 2'd0, 32'h3000, 32'h55, 32'h100, 0, 1);
    applyStimulus(0, 2'd0, 0, 0, 32'h3002, 0, 1);
    chk("t5_hazard_hit",  32'(ld_hazard), 32'd1);
    applyStimulus(0, 2'd0, 0, 0, 32'h3004, 0, 1);
    chk("t5_hazard_miss", 32'(ld_hazard), 32'd0);
    applyStimulus(0, 2'd0, 0, 0, 32'h3000, 1, 1);
    chk("t5_hazard_drained", 32'(ld_hazard), 32'd0);

    $display("[TB] reset mid-drain");
    applyStimulus(1, 2'd0, 32'h8000, 32'h1, 32'h100, 0, 1);
    applyStimulus(1, 2'd0, 32'h8004, 32'h2, 32'h100, 0, 1);
    applyStimulus(1, 2'd0, 32'h8008, 32'h3, 32'h100, 1, 0);
    chk("t6_m_valid",  32'(m_valid),  32'd0);
    chk("t6_count",    32'(count),    32'd0);
    chk("t6_st_ready", 32'(st_ready), 32'd1);
    chk("t6_m_byteen", 32'(m_byteen), 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    32'h4000 + 32'($urandom_range(0, 15)), $urandom,
                    32'h4000 + 32'($urandom_range(0, 15)),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
